// File: rtl/tcdm_varlat_pkg.sv
// Shared definitions for the variable-latency TCDM bank arbiter.
//   arb_state_e : bank-side transaction state (IDLE / INFLIGHT)
//   wrap_inc    : round-robin pointer increment that wraps at n
package tcdm_varlat_pkg;

  typedef enum logic [0:0] {
    IDLE     = 1'b0,
    INFLIGHT = 1'b1
  } arb_state_e;

  // Next round-robin position after idx, wrapping to 0 after n-1.
  function automatic int unsigned wrap_inc(input int unsigned idx, input int unsigned n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/varlat_bank_arbiter_if.sv
// Bundles the master-side fan-in and the bank-side port of one bank arbiter.
// Signal names are seen from the arbiter: _i are arbiter inputs, _o outputs.
//   req_i/data_i      : per-master request and payload from the address decoders
//   gnt_o             : per-master grant (one-hot or zero)
//   vld_o/rdata_o     : per-master response valid (one-hot or zero) and data
//   req_o/data_o      : request and payload towards the bank
//   gnt_i             : bank grant
//   vld_i/rdata_i     : bank response valid and data
//   dbg_*             : FSM state and arbitration registers, observation only
//
// Handshake semantics: a request transfers in the cycle where req and gnt
// are both high; a requester keeps req and payload stable until granted.
// A response is a single-cycle vld pulse with data valid in that cycle; there
// is no back-pressure on responses.
interface varlat_bank_arbiter_if #(
  parameter int NumIn         = 4,
  parameter int ReqDataWidth  = 32,
  parameter int RespDataWidth = 32
);
  import tcdm_varlat_pkg::*;

  localparam int LogNumIn = (NumIn > 1) ? $clog2(NumIn) : 1;

  logic [NumIn-1:0]                    req_i;
  logic [NumIn-1:0][ReqDataWidth-1:0]  data_i;
  logic [NumIn-1:0]                    gnt_o;
  logic [NumIn-1:0]                    vld_o;
  logic [NumIn-1:0][RespDataWidth-1:0] rdata_o;
  logic                                req_o;
  logic [ReqDataWidth-1:0]             data_o;
  logic                                gnt_i;
  logic                                vld_i;
  logic [RespDataWidth-1:0]            rdata_i;

  arb_state_e                          dbg_state;
  logic [LogNumIn-1:0]                 dbg_owner;
  logic [LogNumIn-1:0]                 dbg_rr_ptr;
  logic                                dbg_locked;

  // Arbiter view.
  modport slave (
    input  req_i, data_i, gnt_i, vld_i, rdata_i,
    output gnt_o, vld_o, rdata_o, req_o, data_o,
    output dbg_state, dbg_owner, dbg_rr_ptr, dbg_locked
  );

  // Environment view (decoders + bank).
  modport master (
    output req_i, data_i, gnt_i, vld_i, rdata_i,
    input  gnt_o, vld_o, rdata_o, req_o, data_o,
    input  dbg_state, dbg_owner, dbg_rr_ptr, dbg_locked
  );

endinterface

// File: rtl/varlat_rr_picker.sv
// Combinational round-robin picker.
//   req_i : request vector
//   ptr_i : highest-priority index this cycle
//   idx_o : first requesting index at or after ptr_i, searching cyclically
//   any_o : at least one request present
module varlat_rr_picker #(
  parameter int NumIn    = 4,
  parameter int LogNumIn = (NumIn > 1) ? $clog2(NumIn) : 1
) (
  input  logic [NumIn-1:0]    req_i,
  input  logic [LogNumIn-1:0] ptr_i,
  output logic [LogNumIn-1:0] idx_o,
  output logic                any_o
);

  int   cand;
  logic found;

  always_comb begin
    idx_o = '0;
    found = 1'b0;
    cand  = 0;
    for (int i = 0; i < NumIn; i++) begin
      cand = (int'(ptr_i) + i) % NumIn;
      if (!found && req_i[cand]) begin
        idx_o = LogNumIn'(cand);
        found = 1'b1;
      end
    end
  end

  assign any_o = |req_i;

endmodule

// File: rtl/varlat_bank_arbiter.sv
// Slave-side stage of the variable-latency TCDM crossbar, one per bank.
// Round-robin arbitrates NumIn masters onto one variable-latency bank port,
// tracks the single in-flight transaction and steers the response back to
// its owner.
//   clk_i  : clock
//   rst_ni : asynchronous active-low reset
//   bus    : arbiter side of varlat_bank_arbiter_if (see interface header)
module varlat_bank_arbiter
  import tcdm_varlat_pkg::*;
#(
  parameter int NumIn         = 4,
  parameter int ReqDataWidth  = 32,
  parameter int RespDataWidth = 32
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  varlat_bank_arbiter_if.slave   bus
);

  localparam int LogNumIn = (NumIn > 1) ? $clog2(NumIn) : 1;

  arb_state_e          state_q, state_d;
  logic [LogNumIn-1:0] owner_q, owner_d;
  logic [LogNumIn-1:0] rr_ptr_q, rr_ptr_d;
  logic [LogNumIn-1:0] lock_idx_q, lock_idx_d;
  logic                locked_q, locked_d;

  logic [LogNumIn-1:0] pick_idx;
  logic                any_req;
  logic [LogNumIn-1:0] winner;
  logic                issue;
  logic                req;
  logic                hs;

  varlat_rr_picker #(
    .NumIn    (NumIn),
    .LogNumIn (LogNumIn)
  ) u_picker (
    .req_i (bus.req_i),
    .ptr_i (rr_ptr_q),
    .idx_o (pick_idx),
    .any_o (any_req)
  );

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    rr_ptr_d   = rr_ptr_q;
    lock_idx_d = lock_idx_q;
    locked_d   = locked_q;

    // A stalled winner keeps its slot so its payload cannot change under the bank.
    winner = locked_q ? lock_idx_q : pick_idx;
    // A new request may go out when idle, or in the cycle the current one completes.
    issue  = (state_q == IDLE) || bus.vld_i;
    // rst_ni gating keeps the bank port quiet while reset is held.
    req    = rst_ni && issue && any_req;
    hs     = req && bus.gnt_i;

    bus.req_o  = req;
    bus.data_o = bus.data_i[winner];

    bus.gnt_o = '0;
    if (hs) bus.gnt_o[winner] = 1'b1;

    bus.vld_o = '0;
    if (rst_ni && (state_q == INFLIGHT) && bus.vld_i) bus.vld_o[owner_q] = 1'b1;

    for (int i = 0; i < NumIn; i++) bus.rdata_o[i] = bus.rdata_i;

    if (hs) begin
      owner_d  = winner;
      rr_ptr_d = (NumIn == 1) ? '0 : LogNumIn'(wrap_inc(32'(winner), NumIn));
      locked_d = 1'b0;
      state_d  = INFLIGHT;
    end else begin
      if (req) begin
        locked_d   = 1'b1;
        lock_idx_d = winner;
      end
      if ((state_q == INFLIGHT) && bus.vld_i) state_d = IDLE;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      owner_q    <= '0;
      rr_ptr_q   <= '0;
      lock_idx_q <= '0;
      locked_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      rr_ptr_q   <= rr_ptr_d;
      lock_idx_q <= lock_idx_d;
      locked_q   <= locked_d;
    end
  end

  assign bus.dbg_state  = state_q;
  assign bus.dbg_owner  = owner_q;
  assign bus.dbg_rr_ptr = rr_ptr_q;
  assign bus.dbg_locked = locked_q;

endmodule

// File: tb/tb_varlat_bank_arbiter.sv
module tb_varlat_bank_arbiter;
  import tcdm_varlat_pkg::*;

  localparam int N  = 4;
  localparam int DW = 32;
  localparam int RW = 32;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  varlat_bank_arbiter_if #(.NumIn(N), .ReqDataWidth(DW), .RespDataWidth(RW)) bus4 ();
  varlat_bank_arbiter_if #(.NumIn(1), .ReqDataWidth(DW), .RespDataWidth(RW)) bus1 ();

  varlat_bank_arbiter #(.NumIn(N), .ReqDataWidth(DW), .RespDataWidth(RW)) dut4 (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus4)
  );

  varlat_bank_arbiter #(.NumIn(1), .ReqDataWidth(DW), .RespDataWidth(RW)) dut1 (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus1)
  );

  // ---------------- bookkeeping ----------------
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [N-1:0] oh(input int i);
    logic [N-1:0] r;
    r    = '0;
    r[i] = 1'b1;
    return r;
  endfunction

  // ---------------- driver ----------------
  logic [DW-1:0] dat [N];
  logic [RW-1:0] cur_rdata;

  task automatic drive4(input logic [N-1:0] r, input logic g, input logic v);
    bus4.req_i = r;
    bus4.gnt_i = g;
    bus4.vld_i = v;
    cur_rdata  = $urandom;
    bus4.rdata_i = cur_rdata;
    for (int i = 0; i < N; i++) bus4.data_i[i] = dat[i];
  endtask

  // ---------------- reference model / scoreboard ----------------
  // exp_q holds the one-hot owner of each accepted-but-unanswered request.
  logic [N-1:0] exp_q[$];
  int m_ptr  = 0;    // next master with top priority
  int m_hold = -1;   // master that was offered but not granted, -1 if none

  task automatic model_reset();
    exp_q.delete();
    m_ptr  = 0;
    m_hold = -1;
  endtask

  // Called at the negedge with inputs stable: compares, then advances.
  task automatic model_step();
    bit           busy, can_issue, exp_req, hs;
    int           w;
    logic [N-1:0] exp_gnt, exp_vld;
    busy      = (exp_q.size() != 0);
    can_issue = !busy || bus4.vld_i;
    exp_req   = can_issue && (bus4.req_i != '0);
    w = 0;
    if (m_hold >= 0) w = m_hold;
    else begin
      for (int k = N - 1; k >= 0; k--)
        if (bus4.req_i[(m_ptr + k) % N]) w = (m_ptr + k) % N;
    end
    hs      = exp_req && bus4.gnt_i;
    exp_gnt = hs ? oh(w) : '0;
    exp_vld = (busy && bus4.vld_i) ? exp_q[0] : '0;

    chk("m_req_o", 64'(bus4.req_o), 64'(exp_req));
    chk("m_gnt_o", 64'(bus4.gnt_o), 64'(exp_gnt));
    chk("m_vld_o", 64'(bus4.vld_o), 64'(exp_vld));
    chk("m_state", 64'(bus4.dbg_state == INFLIGHT), 64'(busy));
    chk("m_rr_ptr", 64'(bus4.dbg_rr_ptr), 64'(m_ptr));
    if (exp_req) chk("m_data_o", 64'(bus4.data_o), 64'(dat[w]));
    for (int i = 0; i < N; i++) chk($sformatf("m_rdata_o[%0d]", i), 64'(bus4.rdata_o[i]), 64'(cur_rdata));

    if (busy && bus4.vld_i) void'(exp_q.pop_front());
    if (hs) begin
      exp_q.push_back(oh(w));
      m_ptr  = (w + 1) % N;
      m_hold = -1;
    end else if (exp_req) begin
      m_hold = w;
    end
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic [N-1:0] req;
    logic         gnt;
    logic         vld;
    logic         exp_req;
    logic [N-1:0] exp_gnt;
    logic [N-1:0] exp_vld;
    int           exp_didx;  // -1: data_o not checked
  } vec_t;

  vec_t vt[$];

  task automatic add_vec(input logic [N-1:0] r, input logic g, input logic v, input logic er,
                         input logic [N-1:0] eg, input logic [N-1:0] ev, input int di);
    vec_t e;
    e.req = r; e.gnt = g; e.vld = v; e.exp_req = er;
    e.exp_gnt = eg; e.exp_vld = ev; e.exp_didx = di;
    vt.push_back(e);
  endtask

  // ---------------- test ----------------
  initial begin
    for (int i = 0; i < N; i++) dat[i] = 32'hA000_0000 + 32'(i * 16'h1111);
    bus4.req_i = '0; bus4.gnt_i = 1'b0; bus4.vld_i = 1'b0; bus4.rdata_i = '0;
    for (int i = 0; i < N; i++) bus4.data_i[i] = dat[i];
    bus1.req_i = '0; bus1.gnt_i = 1'b0; bus1.vld_i = 1'b0; bus1.rdata_i = '0;
    bus1.data_i[0] = 32'h5A5A_0001;
    cur_rdata = '0;

    // Reset with all masters requesting: nothing may leak to the ports.
    rst_n = 1'b0;
    drive4('1, 1'b1, 1'b1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_req_o", 64'(bus4.req_o), 64'(0));
    chk("rst_gnt_o", 64'(bus4.gnt_o), 64'(0));
    chk("rst_vld_o", 64'(bus4.vld_o), 64'(0));
    chk("rst_state", 64'(bus4.dbg_state), 64'(IDLE));
    chk("rst_rr_ptr", 64'(bus4.dbg_rr_ptr), 64'(0));
    chk("rst_owner", 64'(bus4.dbg_owner), 64'(0));
    chk("rst_locked", 64'(bus4.dbg_locked), 64'(0));
    @(posedge clk); #1;
    rst_n = 1'b1;
    model_reset();

    // Continuous requests, 1-cycle bank latency: grants 0,1,2,3,0.
    add_vec(4'hF, 1, 0, 1, 4'b0001, 4'b0000, 0);
    add_vec(4'hF, 1, 1, 1, 4'b0010, 4'b0001, 1);
    add_vec(4'hF, 1, 1, 1, 4'b0100, 4'b0010, 2);
    add_vec(4'hF, 1, 1, 1, 4'b1000, 4'b0100, 3);
    add_vec(4'hF, 1, 1, 1, 4'b0001, 4'b1000, 0);
    add_vec(4'h0, 1, 1, 0, 4'b0000, 4'b0001, -1);
    // Master 2 stalls 3 cycles; master 0 joins but must wait for master 2.
    add_vec(4'b0100, 0, 0, 1, 4'b0000, 4'b0000, 2);
    add_vec(4'b0100, 0, 0, 1, 4'b0000, 4'b0000, 2);
    add_vec(4'b0101, 0, 0, 1, 4'b0000, 4'b0000, 2);
    add_vec(4'b0101, 1, 0, 1, 4'b0100, 4'b0000, 2);
    add_vec(4'b0001, 1, 1, 1, 4'b0001, 4'b0100, 0);
    add_vec(4'b0000, 0, 1, 0, 4'b0000, 4'b0001, -1);
    // Grant master 1, bank answers 6 cycles later while master 3 waits.
    add_vec(4'b0010, 1, 0, 1, 4'b0010, 4'b0000, 1);
    for (int c = 0; c < 5; c++) add_vec(4'b1000, 1, 0, 0, 4'b0000, 4'b0000, -1);
    add_vec(4'b1000, 1, 1, 1, 4'b1000, 4'b0010, 3);
    add_vec(4'b0000, 0, 1, 0, 4'b0000, 4'b1000, -1);
    // Stray vld while idle.
    add_vec(4'b0000, 0, 1, 0, 4'b0000, 4'b0000, -1);

    for (int k = 0; k < vt.size(); k++) begin
      drive4(vt[k].req, vt[k].gnt, vt[k].vld);
      @(negedge clk);
      chk($sformatf("v%0d_req_o", k), 64'(bus4.req_o), 64'(vt[k].exp_req));
      chk($sformatf("v%0d_gnt_o", k), 64'(bus4.gnt_o), 64'(vt[k].exp_gnt));
      chk($sformatf("v%0d_vld_o", k), 64'(bus4.vld_o), 64'(vt[k].exp_vld));
      if (vt[k].exp_didx >= 0)
        chk($sformatf("v%0d_data_o", k), 64'(bus4.data_o), 64'(dat[vt[k].exp_didx]));
      model_step();
      @(posedge clk); #1;
    end
    chk("idle_after_stray_vld", 64'(bus4.dbg_state), 64'(IDLE));

    // Reset while master 2 is in flight; late vld afterwards must be dropped.
    drive4(4'b0100, 1, 0);
    @(negedge clk);
    chk("r5_gnt2", 64'(bus4.gnt_o), 64'(4'b0100));
    model_step();
    @(posedge clk); #1;
    chk("r5_inflight", 64'(bus4.dbg_state), 64'(INFLIGHT));
    chk("r5_owner2", 64'(bus4.dbg_owner), 64'(2));
    rst_n = 1'b0;
    drive4(4'hF, 1, 1);
    #2;
    chk("r5_rst_req_o", 64'(bus4.req_o), 64'(0));
    chk("r5_rst_gnt_o", 64'(bus4.gnt_o), 64'(0));
    chk("r5_rst_vld_o", 64'(bus4.vld_o), 64'(0));
    @(posedge clk); #1;
    rst_n = 1'b1;
    model_reset();
    drive4(4'b0000, 0, 1);
    @(negedge clk);
    chk("r5_late_vld", 64'(bus4.vld_o), 64'(0));
    chk("r5_rr_ptr", 64'(bus4.dbg_rr_ptr), 64'(0));
    model_step();
    @(posedge clk); #1;
    drive4(4'hF, 1, 0);
    @(negedge clk);
    chk("r5_first_gnt", 64'(bus4.gnt_o), 64'(4'b0001));
    model_step();
    @(posedge clk); #1;

    // Randomized traffic against the model.
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++) dat[i] = $urandom;
      drive4(N'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), ($urandom_range(0, 2) != 0));
      @(negedge clk);
      model_step();
      @(posedge clk); #1;
    end

    // Single-master instance: vld every 2nd cycle, one grant per response.
    begin
      int grants, resps;
      grants = 0;
      resps  = 0;
      for (int c = 0; c < 8; c++) begin
        bus1.req_i   = 1'b1;
        bus1.gnt_i   = 1'b1;
        bus1.vld_i   = (c % 2 == 0) && (c > 0);
        bus1.rdata_i = $urandom;
        @(negedge clk);
        chk($sformatf("n1_c%0d_gnt_o", c), 64'(bus1.gnt_o), 64'(c % 2 == 0));
        chk($sformatf("n1_c%0d_vld_o", c), 64'(bus1.vld_o), 64'((c % 2 == 0) && (c > 0)));
        chk($sformatf("n1_c%0d_req_o", c), 64'(bus1.req_o), 64'(c % 2 == 0));
        chk($sformatf("n1_c%0d_rdata", c), 64'(bus1.rdata_o[0]), 64'(bus1.rdata_i));
        chk($sformatf("n1_c%0d_rr_ptr", c), 64'(bus1.dbg_rr_ptr), 64'(0));
        if (bus1.req_o) chk($sformatf("n1_c%0d_data", c), 64'(bus1.data_o), 64'(32'h5A5A_0001));
        if (bus1.gnt_o[0]) grants++;
        if (bus1.vld_o[0]) resps++;
        @(posedge clk); #1;
      end
      chk("n1_grants", 64'(grants), 64'(4));
      chk("n1_resps", 64'(resps), 64'(3));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
